// File: rtl/pipe_pkg.sv
// Shared constants and beat layout for the pipelined channel multiplexer.
package pipe_pkg;

    localparam int PIPE_WIDTH_DEF  = 5;
    localparam int PIPE_NUM_IN_DEF = 2;

    // Beat at the default width; modules re-declare the same shape at their own WIDTH.
    typedef struct packed {
        logic [PIPE_WIDTH_DEF-1:0] data;
        logic                      err;
    } pipe_beat_t;

endpackage

// File: rtl/pipe_mux_sel.sv
// Combinational channel select with range check; an out-of-range index yields zero data and err=1.
module pipe_mux_sel
    import pipe_pkg::*;
#(
    parameter int WIDTH  = PIPE_WIDTH_DEF,
    parameter int NUM_IN = PIPE_NUM_IN_DEF,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        sel_data,
    output logic                    sel_err
);

    // Only indices below NUM_IN match a channel; anything else falls through to the error default.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_mux.sv
// Channel multiplexer feeding a two-entry skid buffer with valid/ready handshakes on both sides.
module pipe_mux
    import pipe_pkg::*;
#(
    parameter int WIDTH  = PIPE_WIDTH_DEF,
    parameter int NUM_IN = PIPE_NUM_IN_DEF,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } beat_t;

    logic             m_valid;
    logic             s_valid;
    beat_t            m_beat;
    beat_t            s_beat;
    beat_t            sel_beat;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             m_free;

    pipe_mux_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .sel_data (sel_data),
        .sel_err  (sel_err)
    );

    assign sel_beat = '{data: sel_data, err: sel_err};

    // in_ready depends only on the skid register, so out_ready never reaches it combinationally.
    assign accept = in_valid && !s_valid;
    assign m_free = !m_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_beat  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_beat  <= s_beat;
                s_valid <= 1'b0;
            end else begin
                m_valid <= accept;
                if (accept) begin
                    m_beat <= sel_beat;
                end
            end
        end else if (accept) begin
            s_valid <= 1'b1;
        end
    end

    // Skid data needs no reset: it is only observed once s_valid has been set.
    always_ff @(posedge clk) begin
        if (accept && !m_free) begin
            s_beat <= sel_beat;
        end
    end

    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_beat.data;
    assign out_err   = m_beat.err;

endmodule

// File: tb/tb_pipe_mux.sv
// Directed and randomized checks of pipe_mux against a queue-based reference model.
module tb_pipe_mux;

    localparam int SOAK_CYCLES = 10000;

    logic clk;
    logic rst_n;
    int   num_checks;
    int   num_failures;
    int   soak_done;
    logic soak_start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Directed instance, default geometry.
    logic       d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_out_err;
    logic [0:0] d2_in_sel;
    logic [9:0] d2_in_data;
    logic [4:0] d2_out_data;

    pipe_mux #(.WIDTH(5), .NUM_IN(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(d2_flush),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_sel(d2_in_sel), .in_data(d2_in_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data), .out_err(d2_out_err)
    );

    // Directed instance with a non power-of-two channel count for the range check.
    logic        d3_flush, d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_out_err;
    logic [1:0]  d3_in_sel;
    logic [14:0] d3_in_data;
    logic [4:0]  d3_out_data;

    pipe_mux #(.WIDTH(5), .NUM_IN(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(d3_flush),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_sel(d3_in_sel), .in_data(d3_in_data),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_data(d3_out_data), .out_err(d3_out_err)
    );

    // Drive u_d2 at a falling edge, then return at the falling edge after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [0:0] sel, input logic [9:0] data,
                                 input logic ordy, input logic fl);
        d2_in_valid  = v;
        d2_in_sel    = sel;
        d2_in_data   = data;
        d2_out_ready = ordy;
        d2_flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Random soak instances; each keeps an ordered queue of expected {err,data} beats.
    for (genvar g = 0; g < 3; g++) begin : g_soak
        localparam int SW = (g == 0) ? 1 : (g == 1) ? 5 : 32;
        localparam int SN = (g == 0) ? 2 : (g == 1) ? 5 : 16;
        localparam int SS = $clog2(SN);

        logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
        logic [SS-1:0] s_in_sel;
        logic [SN*SW-1:0] s_in_data;
        logic [SW-1:0] s_out_data;

        pipe_mux #(.WIDTH(SW), .NUM_IN(SN)) u_dut (
            .clk(clk), .rst_n(rst_n), .flush(s_flush),
            .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sel(s_in_sel), .in_data(s_in_data),
            .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_err(s_out_err)
        );

        initial begin
            logic [SW:0] exp_q[$];
            logic [SW:0] beat;
            logic        pop_now;
            logic        push_now;
            int          sel_i;
            s_flush     = 1'b0;
            s_in_valid  = 1'b0;
            s_out_ready = 1'b0;
            s_in_sel    = '0;
            s_in_data   = '0;
            wait (soak_start);
            for (int c = 0; c < SOAK_CYCLES; c++) begin
                @(negedge clk);
                checkOutput("soak_out_valid", 32'(s_out_valid), 32'(exp_q.size() > 0));
                checkOutput("soak_in_ready", 32'(s_in_ready), 32'(exp_q.size() < 2));
                if (s_out_valid && exp_q.size() > 0) begin
                    checkOutput("soak_out_data", 32'(s_out_data), 32'(exp_q[0][SW-1:0]));
                    checkOutput("soak_out_err", 32'(s_out_err), 32'(exp_q[0][SW]));
                end
                s_flush     = ($urandom_range(99) == 0);
                s_in_valid  = 1'($urandom_range(1));
                s_out_ready = ($urandom_range(3) != 0);
                s_in_sel    = SS'($urandom);
                for (int k = 0; k < SN; k++) begin
                    s_in_data[k*SW +: SW] = SW'($urandom);
                end
                sel_i = int'(s_in_sel);
                if (sel_i < SN) beat = {1'b0, s_in_data[sel_i*SW +: SW]};
                else            beat = {1'b1, {SW{1'b0}}};
                pop_now  = (exp_q.size() > 0) && s_out_ready;
                push_now = s_in_valid && (exp_q.size() < 2);
                if (s_flush) begin
                    exp_q.delete();
                end else begin
                    if (pop_now)  void'(exp_q.pop_front());
                    if (push_now) exp_q.push_back(beat);
                end
            end
            soak_done++;
        end
    end

    initial begin
        num_checks   = 0;
        num_failures = 0;
        soak_done    = 0;
        soak_start   = 1'b0;
        rst_n        = 1'b0;
        d2_flush = 1'b0; d2_in_valid = 1'b0; d2_out_ready = 1'b0; d2_in_sel = '0; d2_in_data = '0;
        d3_flush = 1'b0; d3_in_valid = 1'b0; d3_out_ready = 1'b1; d3_in_sel = '0; d3_in_data = '0;

        @(negedge clk);
        checkOutput("rst_out_valid", 32'(d2_out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(d2_in_ready), 32'd1);
        checkOutput("rst_out_data", 32'(d2_out_data), 32'd0);
        checkOutput("rst_out_err", 32'(d2_out_err), 32'd0);
        rst_n = 1'b1;

        $display("[TB] streaming");
        applyStimulus(1'b1, 1'b0, {5'h1C, 5'h03}, 1'b1, 1'b0);
        checkOutput("stream_valid0", 32'(d2_out_valid), 32'd1);
        checkOutput("stream_data0", 32'(d2_out_data), 32'h03);
        checkOutput("stream_err0", 32'(d2_out_err), 32'd0);
        applyStimulus(1'b1, 1'b1, {5'h1C, 5'h03}, 1'b1, 1'b0);
        checkOutput("stream_valid1", 32'(d2_out_valid), 32'd1);
        checkOutput("stream_data1", 32'(d2_out_data), 32'h1C);
        checkOutput("stream_err1", 32'(d2_out_err), 32'd0);
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
        checkOutput("stream_empty", 32'(d2_out_valid), 32'd0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b0, {5'h00, 5'h11}, 1'b0, 1'b0);
        checkOutput("bp_data_a", 32'(d2_out_data), 32'h11);
        checkOutput("bp_ready_a", 32'(d2_in_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, {5'h00, 5'h12}, 1'b0, 1'b0);
        checkOutput("bp_ready_b", 32'(d2_in_ready), 32'd0);
        checkOutput("bp_hold_a", 32'(d2_out_data), 32'h11);
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
        checkOutput("bp_valid_b", 32'(d2_out_valid), 32'd1);
        checkOutput("bp_data_b", 32'(d2_out_data), 32'h12);
        checkOutput("bp_ready_after", 32'(d2_in_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
        checkOutput("bp_empty", 32'(d2_out_valid), 32'd0);

        $display("[TB] flush");
        applyStimulus(1'b1, 1'b0, {5'h00, 5'h05}, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, {5'h00, 5'h06}, 1'b0, 1'b0);
        checkOutput("fl_full_ready", 32'(d2_in_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, {5'h1C, 5'h07}, 1'b0, 1'b1);
        checkOutput("fl_out_valid", 32'(d2_out_valid), 32'd0);
        checkOutput("fl_in_ready", 32'(d2_in_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, {5'h00, 5'h07}, 1'b1, 1'b1);
        checkOutput("fl_drop_accept", 32'(d2_out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
        checkOutput("fl_no_ghost", 32'(d2_out_valid), 32'd0);

        $display("[TB] async reset mid-stream");
        applyStimulus(1'b1, 1'b0, {5'h00, 5'h08}, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, {5'h00, 5'h09}, 1'b0, 1'b0);
        checkOutput("ar_full_ready", 32'(d2_in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("ar_out_valid", 32'(d2_out_valid), 32'd0);
        checkOutput("ar_in_ready", 32'(d2_in_ready), 32'd1);
        checkOutput("ar_out_data", 32'(d2_out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, {5'h00, 5'h0D}, 1'b1, 1'b0);
        checkOutput("ar_first_valid", 32'(d2_out_valid), 32'd1);
        checkOutput("ar_first_data", 32'(d2_out_data), 32'h0D);
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);

        $display("[TB] out-of-range select");
        d3_in_valid = 1'b1;
        d3_in_sel   = 2'd3;
        d3_in_data  = {5'h0A, 5'h15, 5'h07};
        @(posedge clk); @(negedge clk);
        checkOutput("oor_valid", 32'(d3_out_valid), 32'd1);
        checkOutput("oor_data", 32'(d3_out_data), 32'd0);
        checkOutput("oor_err", 32'(d3_out_err), 32'd1);
        d3_in_sel = 2'd2;
        @(posedge clk); @(negedge clk);
        checkOutput("sel2_data", 32'(d3_out_data), 32'h0A);
        checkOutput("sel2_err", 32'(d3_out_err), 32'd0);
        d3_in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checkOutput("sel_empty", 32'(d3_out_valid), 32'd0);

        $display("[TB] random soak");
        soak_start = 1'b1;
        for (int c = 0; c < SOAK_CYCLES + 100 && soak_done < 3; c++) begin
            @(negedge clk);
        end
        checkOutput("soak_done", 32'(soak_done), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
        $finish;
    end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter WIDTH, default 5: bit width of each data channel.
REQ-002 Parameter NUM_IN, default 2: number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN): select width, derived and not overridden.
REQ-004 clk  input  1: single clock, rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 flush  input  1: synchronous discard of all held data.
REQ-007 in_valid  input  1: upstream offers a beat.
REQ-008 in_ready  output  1: block accepts a beat this cycle.
REQ-009 in_sel  input  SEL_W: channel index for the offered beat.
REQ-010 in_data  input  NUM_IN*WIDTH: packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 out_valid  output  1: output beat present.
REQ-012 out_ready  input  1: downstream accepts the beat.
REQ-013 out_data  output  WIDTH: selected channel value.
REQ-014 out_err  output  1: the beat's in_sel was >= NUM_IN.

Function
REQ-015 Transfer occurs on an edge where valid and ready are both 1; in_* and out_* are independent handshakes.
REQ-016 Selection is done on input: the stored beat is {in_data[in_sel], err}. When in_sel >= NUM_IN, the stored data is all-zero and err is 1.
REQ-017 Storage is a two-entry skid buffer: main register (M) drives out_*, and skid register (S) holds one overflow beat.
REQ-018 in_ready = !S.valid, registered, with no combinational path from out_ready.
REQ-019 out_valid = M.valid; out_data and out_err come from M only.
REQ-020 Latency: a beat accepted at edge n appears on out_* after edge n, provided M was empty or drained at edge n.
REQ-021 M loads from S when S.valid and M is empty or drains; otherwise M loads the accepted input beat.
REQ-022 When an input is accepted while M.valid and !out_ready, the beat goes to S and in_ready drops next cycle.
REQ-023 On simultaneous drain of M with a valid S and a new input accepted: S moves to M, and the input is impossible because in_ready=0.
REQ-024 Order is strictly preserved, with no beat lost or duplicated; maximum occupancy is 2.
REQ-025 out_data and out_err are stable while out_valid=1 and out_ready=0.
REQ-026 Full throughput is one beat per cycle when out_ready is held at 1.
REQ-027 flush=1 at an edge clears M.valid and S.valid, and any in_* transfer on that edge is discarded. in_ready is 1 after the edge.
REQ-028 flush has priority over all handshakes in the same cycle.
REQ-029 Data registers are don't-care when the matching valid is 0; only the valid bits need reset.

Reset
REQ-030 rst_n low asynchronously forces M.valid=0, S.valid=0, out_valid=0, in_ready=1, out_data=0, and out_err=0.
REQ-031 Reset asserted mid-transfer drops all held beats with no partial output; the first accept is allowed at the first edge after rst_n rises.

Structure
REQ-032 A shared package pipe_pkg holds the default constants PIPE_WIDTH_DEF=5 and PIPE_NUM_IN_DEF=2, and the beat struct {data, err}.
REQ-033 One sub-module, pipe_mux_sel, is the combinational channel select plus range check that produces the beat struct. All state lives in pipe_mux.
REQ-034 The block has no latches, and its combinational outputs are limited to out_* and in_ready driven directly from registers.

Verification
REQ-035 Reset: rst_n=0 mid-stream with M and S full -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
REQ-036 Streaming: WIDTH=5, NUM_IN=2, out_ready=1, beats sel=0 then 1 with ch0=5'h03 and ch1=5'h1C -> out_data is 03 then 1C on consecutive cycles, out_err=0.
REQ-037 Backpressure: out_ready=0, send A=5'h11 then B=5'h12 -> in_ready=0 after B; raise out_ready -> outputs A then B, then in_ready=1.
REQ-038 Out-of-range select: NUM_IN=3, in_sel=3 -> out_data=0 and out_err=1; the next beat with in_sel=2 and ch2=5'h0A -> out_data 0A, out_err=0.
REQ-039 Flush: M and S full, flush=1 with in_valid=1 -> both entries empty and the input dropped; out_valid=0 and in_ready=1 next cycle.
REQ-040 Random soak: 10k cycles with random valid, ready, and sel, across WIDTH 1/5/32 and NUM_IN 2/5/16 -> scoreboard order match with zero loss.
